// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter feeding the single register-file write port.
// Optional contention counter stall_cnt_o is built when RF_WB_ARB_STATS_EN is defined.
module rf_wb_arbiter #(
    parameter  int NUM_REQ = 3,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ*5-1:0]    req_addr_i,
    input  logic [NUM_REQ*32-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic                    reg_write_en_o,
    output logic [4:0]              rd_addr_o,
    output logic [31:0]             rd_data_o
`ifdef RF_WB_ARB_STATS_EN
   ,output logic [31:0]             stall_cnt_o
`endif
);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   ptr_nxt;
    logic               gnt_any;
    logic [NUM_REQ-1:0] ready;
    logic [4:0]         gnt_addr;
    logic [31:0]        gnt_data;

    // Scan from ptr upward with wrap; first valid requester wins.
    always_comb begin
        int j;
        logic [PTR_W-1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        ready   = '0;
        j       = 0;
        idx     = '0;
        if (!flush_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = int'(ptr) + k;
                if (j >= NUM_REQ)
                    j = j - NUM_REQ;
                idx = PTR_W'(j);
                if (!gnt_any && req_valid_i[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
        if (gnt_any)
            ready[gnt_idx] = 1'b1;
    end

    assign req_ready_o = rst_n ? ready : '0;
    assign gnt_addr    = req_addr_i[5*gnt_idx +: 5];
    assign gnt_data    = req_data_i[32*gnt_idx +: 32];
    assign ptr_nxt     = (gnt_idx == PTR_W'(NUM_REQ-1)) ?
                         '0 : gnt_idx + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr            <= '0;
            reg_write_en_o <= 1'b0;
            rd_addr_o      <= '0;
            rd_data_o      <= '0;
        end else if (gnt_any) begin
            ptr            <= ptr_nxt;
            reg_write_en_o <= |gnt_addr;
            rd_addr_o      <= gnt_addr;
            rd_data_o      <= gnt_data;
        end else begin
            reg_write_en_o <= 1'b0;
        end
    end

`ifdef RF_WB_ARB_STATS_EN
    logic contended;

    // More than one bit set means at least one valid requester lost.
    assign contended = |(req_valid_i & (req_valid_i - NUM_REQ'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_o <= '0;
        else if (!flush_i && contended && stall_cnt_o != 32'hFFFF_FFFF)
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed vector bench for rf_wb_arbiter (NUM_REQ=3).
// Vectors run back to back from reset; each checks ready before and outputs after its edge.
module tb_rf_wb_arbiter;

    localparam int N = 3;

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic [N-1:0]  req_valid_i;
    logic [N*5-1:0]  req_addr_i;
    logic [N*32-1:0] req_data_i;
    logic [N-1:0]  req_ready_o;
    logic          reg_write_en_o;
    logic [4:0]    rd_addr_o;
    logic [31:0]   rd_data_o;
`ifdef RF_WB_ARB_STATS_EN
    logic [31:0]   stall_cnt_o;
`endif

    rf_wb_arbiter #(.NUM_REQ(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_addr_i     (req_addr_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .reg_write_en_o (reg_write_en_o),
        .rd_addr_o      (rd_addr_o),
`ifdef RF_WB_ARB_STATS_EN
        .rd_data_o      (rd_data_o),
        .stall_cnt_o    (stall_cnt_o)
`else
        .rd_data_o      (rd_data_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model fed by the write port.
    logic [31:0] rf [32];
    always @(posedge clk)
        if (reg_write_en_o)
            rf[rd_addr_o] <= rd_data_o;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic        flush;
        logic [2:0]  exp_ready;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [19];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [2:0] v,
        input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
        input logic fl, input logic [2:0] r, input logic en,
        input logic [4:0] ea, input logic [31:0] ed);
        vec_t t;
        t.valid = v;
        t.addr  = {a2, a1, a0};
        t.data  = {d2, d1, d0};
        t.flush = fl;
        t.exp_ready = r;
        t.exp_en    = en;
        t.exp_addr  = ea;
        t.exp_data  = ed;
        return t;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++)
            rf[i] = 32'h0;

        // round robin, all three valid
        tbl[0]  = mk(3'b111, 1, 2, 3, 'hA1, 'hA2, 'hA3, 0, 3'b001, 1, 1, 'hA1);
        tbl[1]  = mk(3'b111, 1, 2, 3, 'hA1, 'hA2, 'hA3, 0, 3'b010, 1, 2, 'hA2);
        tbl[2]  = mk(3'b111, 1, 2, 3, 'hA1, 'hA2, 'hA3, 0, 3'b100, 1, 3, 'hA3);
        tbl[3]  = mk(3'b111, 1, 2, 3, 'hA1, 'hA2, 'hA3, 0, 3'b001, 1, 1, 'hA1);
        tbl[4]  = mk(3'b111, 1, 2, 3, 'hA1, 'hA2, 'hA3, 0, 3'b010, 1, 2, 'hA2);
        tbl[5]  = mk(3'b111, 1, 2, 3, 'hA1, 'hA2, 'hA3, 0, 3'b100, 1, 3, 'hA3);
        // single request, then idle (addr/data hold)
        tbl[6]  = mk(3'b001, 5, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 3'b001, 1, 5, 32'hDEAD_BEEF);
        tbl[7]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 5, 32'hDEAD_BEEF);
        // x0 request consumed without a write, ptr moves to 2
        tbl[8]  = mk(3'b010, 0, 0, 0, 0, 32'h1234, 0, 0, 3'b010, 0, 0, 32'h1234);
        tbl[9]  = mk(3'b111, 1, 2, 3, 'hA1, 'hA2, 'hA3, 0, 3'b100, 1, 3, 'hA3);
        // flush for two cycles, req2 granted afterwards
        tbl[10] = mk(3'b100, 0, 0, 9, 0, 0, 'hC2, 1, 3'b000, 0, 3, 'hA3);
        tbl[11] = mk(3'b100, 0, 0, 9, 0, 0, 'hC2, 1, 3'b000, 0, 3, 'hA3);
        tbl[12] = mk(3'b100, 0, 0, 9, 0, 0, 'hC2, 0, 3'b100, 1, 9, 'hC2);
        // same destination from two requesters
        tbl[13] = mk(3'b011, 7, 7, 0, 'h11, 'h22, 0, 0, 3'b001, 1, 7, 'h11);
        tbl[14] = mk(3'b010, 7, 7, 0, 'h11, 'h22, 0, 0, 3'b010, 1, 7, 'h22);
        // lone requester granted back to back, then wrap 2 -> 0 -> 2
        tbl[15] = mk(3'b010, 0, 4, 0, 0, 'h33, 0, 0, 3'b010, 1, 4, 'h33);
        tbl[16] = mk(3'b101, 8, 0, 6, 'h55, 0, 'h44, 0, 3'b100, 1, 6, 'h44);
        tbl[17] = mk(3'b101, 8, 0, 6, 'h55, 0, 'h44, 0, 3'b001, 1, 8, 'h55);
        tbl[18] = mk(3'b101, 8, 0, 6, 'h55, 0, 'h44, 0, 3'b100, 1, 6, 'h44);

        // reset held with every requester valid
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        req_valid_i = 3'b111;
        req_addr_i  = tbl[0].addr;
        req_data_i  = tbl[0].data;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready_o), 32'h0);
        chk("rst_en",    32'(reg_write_en_o), 32'h0);
        chk("rst_addr",  32'(rd_addr_o), 32'h0);
        chk("rst_data",  rd_data_o, 32'h0);
`ifdef RF_WB_ARB_STATS_EN
        chk("rst_stall", stall_cnt_o, 32'h0);
`endif

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst_n       = 1'b1;
            req_valid_i = tbl[i].valid;
            req_addr_i  = tbl[i].addr;
            req_data_i  = tbl[i].data;
            flush_i     = tbl[i].flush;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready_o),
                32'(tbl[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_en", i), 32'(reg_write_en_o),
                32'(tbl[i].exp_en));
            chk($sformatf("v%0d_addr", i), 32'(rd_addr_o),
                32'(tbl[i].exp_addr));
            chk($sformatf("v%0d_data", i), rd_data_o, tbl[i].exp_data);
            if (i == 7)
                chk("rf_x5", rf[5], 32'hDEAD_BEEF);
            if (i == 9)
                chk("rf_x0", rf[0], 32'h0);
            if (i == 14)
                chk("rf_x7_first", rf[7], 32'h11);
            if (i == 15)
                chk("rf_x7_second", rf[7], 32'h22);
        end

        @(negedge clk);
        req_valid_i = 3'b000;
        flush_i     = 1'b0;
`ifdef RF_WB_ARB_STATS_EN
        #1;
        chk("stall_cnt", stall_cnt_o, 32'd11);
`endif

        // reset mid-transfer drops the pending write
        @(negedge clk);
        req_valid_i = 3'b001;
        req_addr_i  = {5'd0, 5'd0, 5'd10};
        req_data_i  = {32'h0, 32'h0, 32'hBB};
        #1;
        chk("mid_ready_pre", 32'(req_ready_o), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_ready_rst", 32'(req_ready_o), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_en",   32'(reg_write_en_o), 32'h0);
        chk("mid_addr", 32'(rd_addr_o), 32'h0);
        chk("mid_data", rd_data_o, 32'h0);
        chk("rf_x10",   rf[10], 32'h0);
`ifdef RF_WB_ARB_STATS_EN
        chk("mid_stall", stall_cnt_o, 32'h0);
`endif
        @(negedge clk);
        req_valid_i = 3'b000;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_en", 32'(reg_write_en_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
